// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a framed byte stream (length, little-endian words,
// XOR checksum) and drives the IMEM write port while holding the core in reset.
module imem_loader #(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_written
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CHK, DONE, ERROR} state_t;

  state_t            state_reg, state_next;
  logic [15:0]       len_reg, len_next;
  logic [1:0]        k_reg, k_next;
  logic [23:0]       word_reg, word_next;
  logic [7:0]        chk_reg, chk_next;
  logic [ADDR_W:0]   wcnt_reg, wcnt_next;
  logic [TW-1:0]     tcnt_reg, tcnt_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] waddr_reg, waddr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [1:0]        errc_reg, errc_next;

  logic        busy;
  logic        hs;
  logic [15:0] len_full;

  assign busy     = (state_reg == LEN0) || (state_reg == LEN1) ||
                    (state_reg == DATA) || (state_reg == CHK);
  assign hs       = in_valid && busy;
  assign len_full = {in_data, len_reg[7:0]};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      len_reg   <= '0;
      k_reg     <= '0;
      word_reg  <= '0;
      chk_reg   <= '0;
      wcnt_reg  <= '0;
      tcnt_reg  <= '0;
      we_reg    <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= '0;
      errc_reg  <= '0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      k_reg     <= k_next;
      word_reg  <= word_next;
      chk_reg   <= chk_next;
      wcnt_reg  <= wcnt_next;
      tcnt_reg  <= tcnt_next;
      we_reg    <= we_next;
      waddr_reg <= waddr_next;
      wdata_reg <= wdata_next;
      errc_reg  <= errc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    k_next     = k_reg;
    word_next  = word_reg;
    chk_next   = chk_reg;
    wcnt_next  = wcnt_reg;
    tcnt_next  = tcnt_reg;
    we_next    = 1'b0;
    waddr_next = waddr_reg;
    wdata_next = wdata_reg;
    errc_next  = errc_reg;

    case (state_reg)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_next = LEN0;
          errc_next  = 2'b00;
          wcnt_next  = '0;
          chk_next   = '0;
          k_next     = '0;
          tcnt_next  = '0;
        end
      end
      LEN0: begin
        if (hs) begin
          len_next[7:0] = in_data;
          state_next    = LEN1;
        end
      end
      LEN1: begin
        if (hs) begin
          len_next[15:8] = in_data;
          if (len_full == 16'd0 || {1'b0, len_full} > DEPTH_L) begin
            state_next = ERROR;
            errc_next  = 2'b01;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (hs) begin
          chk_next = chk_reg ^ in_data;
          k_next   = k_reg + 2'd1;
          case (k_reg)
            2'd0: word_next[7:0]   = in_data;
            2'd1: word_next[15:8]  = in_data;
            2'd2: word_next[23:16] = in_data;
            default: begin
              // Fourth byte: the word goes out on the registered write port next cycle
              we_next    = 1'b1;
              wdata_next = {in_data, word_reg};
              waddr_next = wcnt_reg[ADDR_W-1:0];
              wcnt_next  = wcnt_reg + 1'b1;
              if (16'(wcnt_reg) + 16'd1 == len_reg)
                state_next = CHK;
            end
          endcase
        end
      end
      CHK: begin
        if (hs) begin
          if (in_data == chk_reg) begin
            state_next = DONE;
          end else begin
            state_next = ERROR;
            errc_next  = 2'b11;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Inter-byte watchdog; a handshake always wins over an expiring count
    if (busy) begin
      if (hs) begin
        tcnt_next = '0;
      end else if (tcnt_reg == TW'(TIMEOUT - 1)) begin
        state_next = ERROR;
        errc_next  = 2'b10;
        tcnt_next  = '0;
      end else begin
        tcnt_next = tcnt_reg + 1'b1;
      end
    end
  end

  assign in_ready      = busy;
  assign cpu_hold      = (state_reg != IDLE) && (state_reg != DONE);
  assign done          = (state_reg == DONE);
  assign error         = (state_reg == ERROR);
  assign err_code      = errc_reg;
  assign words_written = wcnt_reg;
  assign mem_we        = we_reg;
  assign mem_waddr     = waddr_reg;
  assign mem_wdata     = wdata_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: nominal, checksum, length, timeout, gap and reset cases
// with hand-computed expected words and status.
module tb_imem_loader;
  localparam int DEPTH = 256;
  localparam int ADDR_W = 8;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   words_written;

  int total = 0;
  int bad = 0;
  int we_count = 0;
  int we_base;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .done(done), .error(error),
    .err_code(err_code), .words_written(words_written)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      we_count++;
      $display("write addr=%0d data=%h", mem_waddr, mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_we"}, 32'(mem_we), 32'd0);
    check({tag, "_waddr"}, 32'(mem_waddr), 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_errc"}, 32'(err_code), 32'd0);
    check({tag, "_ww"}, 32'(words_written), 32'd0);
  endtask

  // Nominal two-word frame; max_gap > 0 inserts random idle cycles between bytes
  task automatic run_frame(input string tag, input logic [7:0] chk_byte, input int max_gap);
    logic [7:0] data [8];
    data = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
    we_base = we_count;
    pulse_start();
    check({tag, "_hold_start"}, 32'(cpu_hold), 32'd1);
    check({tag, "_ready_start"}, 32'(in_ready), 32'd1);
    send(8'h02, $urandom_range(0, max_gap));
    send(8'h00, $urandom_range(0, max_gap));
    for (int i = 0; i < 8; i++) begin
      send(data[i], $urandom_range(0, max_gap));
      if (i == 3) begin
        check({tag, "_we0"}, 32'(mem_we), 32'd1);
        check({tag, "_addr0"}, 32'(mem_waddr), 32'd0);
        check({tag, "_data0"}, mem_wdata, 32'h00500093);
        check({tag, "_ready_wr"}, 32'(in_ready), 32'd1);
      end else if (i == 7) begin
        check({tag, "_we1"}, 32'(mem_we), 32'd1);
        check({tag, "_addr1"}, 32'(mem_waddr), 32'd1);
        check({tag, "_data1"}, mem_wdata, 32'h00A00113);
      end else begin
        check({tag, "_we_quiet"}, 32'(mem_we), 32'd0);
      end
    end
    send(chk_byte, $urandom_range(0, max_gap));
    check({tag, "_nwrites"}, 32'(we_count - we_base), 32'd2);
    check({tag, "_ww"}, 32'(words_written), 32'd2);
  endtask

  initial begin
    // Reset state
    reset_n = 1'b0;
    tick();
    tick();
    check_idle_outputs("reset");
    reset_n = 1'b1;
    tick();

    // Bytes presented before start are not consumed
    in_valid = 1'b1;
    in_data  = 8'h55;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("prestart_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    check("prestart_nowrite", 32'(we_count), 32'd0);

    // Nominal load, back-to-back bytes
    run_frame("nom", 8'h71, 0);
    check("nom_done", 32'(done), 32'd1);
    check("nom_hold", 32'(cpu_hold), 32'd0);
    check("nom_errc", 32'(err_code), 32'd0);
    check("nom_error", 32'(error), 32'd0);
    check("nom_ready", 32'(in_ready), 32'd0);

    // Checksum mismatch
    run_frame("csum", 8'h70, 0);
    check("csum_error", 32'(error), 32'd1);
    check("csum_errc", 32'(err_code), 32'd3);
    check("csum_hold", 32'(cpu_hold), 32'd1);
    check("csum_done", 32'(done), 32'd0);

    // Zero length
    we_base = we_count;
    pulse_start();
    check("len0_done_cleared", 32'(done), 32'd0);
    check("len0_ww_cleared", 32'(words_written), 32'd0);
    send(8'h00, 0);
    check("len0_mid_error", 32'(error), 32'd0);
    send(8'h00, 0);
    check("len0_error", 32'(error), 32'd1);
    check("len0_errc", 32'(err_code), 32'd1);
    check("len0_ready", 32'(in_ready), 32'd0);

    // Length 257 exceeds depth
    pulse_start();
    check("len257_errc_cleared", 32'(err_code), 32'd0);
    send(8'h01, 0);
    send(8'h01, 0);
    check("len257_error", 32'(error), 32'd1);
    check("len257_errc", 32'(err_code), 32'd1);
    tick();
    check("len_nowrite", 32'(we_count - we_base), 32'd0);

    // Timeout after 3 bytes then a stall of TIMEOUT cycles
    we_base = we_count;
    pulse_start();
    send(8'h02, 0);
    send(8'h00, 0);
    send(8'h93, 0);
    repeat (TIMEOUT - 1) tick();
    check("tmo_early", 32'(error), 32'd0);
    check("tmo_early_ready", 32'(in_ready), 32'd1);
    tick();
    check("tmo_error", 32'(error), 32'd1);
    check("tmo_errc", 32'(err_code), 32'd2);
    check("tmo_ready", 32'(in_ready), 32'd0);
    check("tmo_hold", 32'(cpu_hold), 32'd1);
    check("tmo_nowrite", 32'(we_count - we_base), 32'd0);

    // Nominal frame with random inter-byte gaps
    run_frame("gap", 8'h71, 5);
    check("gap_done", 32'(done), 32'd1);
    check("gap_errc", 32'(err_code), 32'd0);

    // Reset after the fifth byte, then a clean reload
    pulse_start();
    send(8'h02, 0);
    send(8'h00, 0);
    send(8'h93, 0);
    send(8'h00, 0);
    send(8'h50, 0);
    reset_n = 1'b0;
    tick();
    check_idle_outputs("midrst");
    reset_n = 1'b1;
    tick();
    run_frame("reload", 8'h71, 0);
    check("reload_done", 32'(done), 32'd1);
    check("reload_hold", 32'(cpu_hold), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
